// File: rtl/axi_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_host_master
// Description : Single-outstanding AXI4-Lite style initiator. Converts a
//               write / read / poll-until-match command stream into AXI
//               transactions on a 64-bit slave port and returns exactly one
//               response per command.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_host_master #(
    parameter int POLL_MAX = 1024,
    parameter int POLL_GAP = 16
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic                          cmd_poll,
    input  logic [31:0]                   cmd_addr,
    input  logic [63:0]                   cmd_wdata,
    input  logic [7:0]                    cmd_wstrb,
    input  logic [63:0]                   cmd_mask,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [63:0]                   rsp_data,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic [$clog2(POLL_MAX+1)-1:0] rsp_count,

    output logic [31:0]                   M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [63:0]                   M_AXI_WDATA,
    output logic [7:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [31:0]                   M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [63:0]                   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int CW = $clog2(POLL_MAX + 1);
    // Gap counter needs at least one bit even when no gap is configured.
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_GAP  = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            write_q, write_d;
    logic            poll_q, poll_d;
    logic [31:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [63:0]     mask_q, mask_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic            timeout_q, timeout_d;

    logic            w_aw_hs;
    logic            w_w_hs;

    // Handshake/valid outputs decode directly from state so that a reset
    // edge drops every valid in the same cycle.
    assign cmd_ready     = (state_q == S_IDLE) && !reset;
    assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WB);
    assign M_AXI_ARVALID = (state_q == S_RA);
    assign M_AXI_RREADY  = (state_q == S_RD);
    assign rsp_valid     = (state_q == S_RSP);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;

    assign rsp_write     = write_q;
    assign rsp_data      = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = timeout_q;
    assign rsp_count     = cnt_q;

    assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            poll_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            mask_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            gap_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            poll_q    <= poll_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            mask_q    <= mask_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        poll_d    = poll_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        mask_d    = mask_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d   = cmd_write;
                    poll_d    = cmd_poll && !cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    mask_d    = cmd_mask;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    gap_d     = '0;
                    rdata_d   = '0;
                    resp_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = cmd_write ? S_WR : S_RA;
                end
            end
            S_WR: begin
                // AW and W complete independently; move on once both are done.
                if (w_aw_hs) aw_done_d = 1'b1;
                if (w_w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    state_d = S_RSP;
                end
            end
            S_RA: begin
                if (M_AXI_ARREADY) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    if (!poll_q || (M_AXI_RRESP != 2'b00) ||
                        ((M_AXI_RDATA & mask_q) == wdata_q)) begin
                        state_d = S_RSP;
                    end else if (cnt_q == CW'(POLL_MAX)) begin
                        timeout_d = 1'b1;
                        state_d   = S_RSP;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_RA;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    state_d = S_RA;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_host_master
// Description : Directed self-checking bench for axi_host_master with a
//               reactive AXI-Lite slave model and handshake monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_host_master;

    localparam int PM = 4;
    localparam int PG = 16;
    localparam int CW = $clog2(PM + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic          cmd_poll = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [63:0]   cmd_wdata = '0;
    logic [7:0]    cmd_wstrb = '0;
    logic [63:0]   cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [63:0]   rsp_data;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [CW-1:0] rsp_count;

    logic [31:0]   AWADDR;
    logic          AWVALID;
    logic          AWREADY = 1'b0;
    logic [63:0]   WDATA;
    logic [7:0]    WSTRB;
    logic          WVALID;
    logic          WREADY = 1'b0;
    logic [1:0]    BRESP = 2'b00;
    logic          BVALID = 1'b0;
    logic          BREADY;
    logic [31:0]   ARADDR;
    logic          ARVALID;
    logic          ARREADY = 1'b0;
    logic [63:0]   RDATA = '0;
    logic [1:0]    RRESP = 2'b00;
    logic          RVALID = 1'b0;
    logic          RREADY;

    axi_host_master #(.POLL_MAX(PM), .POLL_GAP(PG)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_poll(cmd_poll), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .rsp_count(rsp_count),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
        .M_AXI_WREADY(WREADY), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID),
        .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave configuration, written by the stimulus process.
    int          aw_wait = 0;
    int          w_wait = 0;
    logic        b_hold = 1'b0;
    logic [1:0]  bresp_val = 2'b00;
    logic [63:0] rtab [0:31];
    logic [1:0]  rresp_tab [0:31];

    // Monitor state.
    int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    logic [31:0] aw_addr_l = '0, ar_addr_l = '0;
    logic [63:0] wdata_l = '0;
    logic [7:0]  wstrb_l = '0;
    int          ar_cyc [0:31];
    logic        overlap_seen = 1'b0;
    logic        bready_early = 1'b0;

    // Cycle counter and handshake monitor; slave-side counters reset with the DUT.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (AWVALID && ARVALID) overlap_seen <= 1'b1;
        if (BREADY && !((aw_n > b_n) && (w_n > b_n))) bready_early <= 1'b1;
        if (reset) begin
            aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
        end else begin
            if (AWVALID && AWREADY) begin aw_n <= aw_n + 1; aw_addr_l <= AWADDR; end
            if (WVALID && WREADY) begin w_n <= w_n + 1; wdata_l <= WDATA; wstrb_l <= WSTRB; end
            if (BVALID && BREADY) b_n <= b_n + 1;
            if (ARVALID && ARREADY) begin
                ar_n <= ar_n + 1;
                ar_addr_l <= ARADDR;
                if (ar_n < 32) ar_cyc[ar_n] <= cyc;
            end
            if (RVALID && RREADY) r_n <= r_n + 1;
        end
    end

    // Reactive slave: drives its outputs on the falling edge.
    initial begin : slave
        int aw_age;
        int w_age;
        aw_age = 0;
        w_age  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
                BVALID = 1'b0; RVALID = 1'b0;
                aw_age = 0; w_age = 0;
            end else begin
                if (AWVALID) aw_age++; else aw_age = 0;
                if (WVALID)  w_age++;  else w_age  = 0;
                AWREADY = AWVALID && (aw_age > aw_wait);
                WREADY  = WVALID && (w_age > w_wait);
                ARREADY = ARVALID;
                BVALID  = !b_hold && (aw_n > b_n) && (w_n > b_n);
                BRESP   = bresp_val;
                RVALID  = (ar_n > r_n);
                RDATA   = rtab[r_n % 32];
                RRESP   = rresp_tab[r_n % 32];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer a command and return the sample cycle right after its accept edge.
    task automatic send(input logic wr, input logic pl, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s, input logic [63:0] m,
                        output int t_acc);
        logic ok;
        ok = 1'b0;
        cmd_write = wr; cmd_poll = pl; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s; cmd_mask = m;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        t_acc = cyc;
        check("cmd_accepted", {63'd0, ok}, 64'd1);
    endtask

    // Wait (bounded) for rsp_valid; leaves the response un-consumed.
    task automatic wait_rsp(input int budget, output int t_rsp);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) break;
        end
        t_rsp = cyc;
        check("rsp_arrived", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin : stim
        int ta, tr, base_ar, base_b, rb;
        for (int i = 0; i < 32; i++) begin
            rtab[i] = '0;
            rresp_tab[i] = 2'b00;
        end

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_valids", {58'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 64'd0);
        check("rst_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("rst_data", rsp_data, 64'd0);
        check("rst_awaddr", {32'd0, AWADDR}, 64'd0);
        reset = 1'b0;
        #1;
        check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // 1: zero-wait write.
        send(1'b1, 1'b0, 32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, ta);
        check("t1_awvalid_T1", {63'd0, AWVALID}, 64'd1);
        check("t1_wvalid_T1", {63'd0, WVALID}, 64'd1);
        check("t1_bready_T1", {63'd0, BREADY}, 64'd0);
        wait_rsp(50, tr);
        check("t1_latency", 64'(tr - ta), 64'd2);
        check("t1_rsp_write", {63'd0, rsp_write}, 64'd1);
        check("t1_rsp_resp", {62'd0, rsp_resp}, 64'd0);
        check("t1_rsp_count", 64'(rsp_count), 64'd0);
        check("t1_rsp_data", rsp_data, 64'd0);
        check("t1_awaddr", {32'd0, aw_addr_l}, 64'h10);
        check("t1_wdata", wdata_l, 64'h0123_4567_89AB_CDEF);
        check("t1_wstrb", {56'd0, wstrb_l}, 64'hFF);
        consume();

        // Plain zero-wait read.
        rb = r_n;
        rtab[rb] = 64'hDEAD_BEEF_CAFE_F00D;
        send(1'b0, 1'b0, 32'h40, 64'd0, 8'd0, 64'd0, ta);
        check("rd_arvalid_T1", {63'd0, ARVALID}, 64'd1);
        wait_rsp(50, tr);
        check("rd_latency", 64'(tr - ta), 64'd2);
        check("rd_data", rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("rd_count", 64'(rsp_count), 64'd1);
        check("rd_write", {63'd0, rsp_write}, 64'd0);
        check("rd_araddr", {32'd0, ar_addr_l}, 64'h40);
        consume();

        // 2: AWREADY three cycles before WREADY.
        aw_wait = 0; w_wait = 3;
        base_b = b_n;
        send(1'b1, 1'b0, 32'h20, 64'h1111_2222_3333_4444, 8'h0F, 64'd0, ta);
        @(posedge clk); #1;
        check("t2_aw_dropped", {63'd0, AWVALID}, 64'd0);
        check("t2_w_held", {63'd0, WVALID}, 64'd1);
        check("t2_wdata_stable", WDATA, 64'h1111_2222_3333_4444);
        wait_rsp(50, tr);
        check("t2_latency", 64'(tr - ta), 64'd5);
        check("t2_wstrb", {56'd0, wstrb_l}, 64'h0F);
        consume();
        repeat (3) @(posedge clk);
        #1;
        check("t2_single_b", 64'(b_n - base_b), 64'd1);
        check("t2_no_extra_rsp", {63'd0, rsp_valid}, 64'd0);
        w_wait = 0;

        // 3: poll until bit0 clears; slave returns 1,1,0.
        rb = r_n; base_ar = ar_n;
        rtab[rb] = 64'd1; rtab[rb+1] = 64'd1; rtab[rb+2] = 64'd0;
        send(1'b0, 1'b1, 32'h30, 64'd0, 8'd0, 64'd1, ta);
        wait_rsp(400, tr);
        check("t3_ar_count", 64'(ar_n - base_ar), 64'd3);
        check("t3_rsp_count", 64'(rsp_count), 64'd3);
        check("t3_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("t3_data", rsp_data, 64'd0);
        check("t3_araddr", {32'd0, ar_addr_l}, 64'h30);
        check("t3_gap01", {63'd0, (ar_cyc[base_ar+1] - ar_cyc[base_ar]) >= 17}, 64'd1);
        check("t3_gap12", {63'd0, (ar_cyc[base_ar+2] - ar_cyc[base_ar+1]) >= 17}, 64'd1);
        consume();

        // 4: poll never matches; exhausts POLL_MAX.
        rb = r_n; base_ar = ar_n;
        for (int i = 0; i < 6; i++) rtab[rb+i] = 64'd1;
        send(1'b0, 1'b1, 32'h30, 64'd0, 8'd0, 64'd1, ta);
        wait_rsp(400, tr);
        check("t4_ar_count", 64'(ar_n - base_ar), 64'd4);
        check("t4_timeout", {63'd0, rsp_timeout}, 64'd1);
        check("t4_rsp_count", 64'(rsp_count), 64'd4);
        check("t4_data", rsp_data, 64'd1);
        consume();

        // 5: error response ends a poll immediately.
        rb = r_n; base_ar = ar_n;
        rtab[rb] = 64'd1; rresp_tab[rb] = 2'b10;
        send(1'b0, 1'b1, 32'h30, 64'd0, 8'd0, 64'd1, ta);
        wait_rsp(100, tr);
        check("t5_latency", 64'(tr - ta), 64'd2);
        check("t5_resp", {62'd0, rsp_resp}, 64'd2);
        check("t5_timeout", {63'd0, rsp_timeout}, 64'd0);
        check("t5_count", 64'(rsp_count), 64'd1);
        consume();
        repeat (30) @(posedge clk);
        #1;
        check("t5_no_more_ar", 64'(ar_n - base_ar), 64'd1);

        // 6: response held off, then reset while waiting for B.
        bresp_val = 2'b01;
        send(1'b1, 1'b0, 32'h50, 64'h55, 8'h01, 64'd0, ta);
        wait_rsp(50, tr);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t6_rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
            check("t6_rsp_resp_held", {62'd0, rsp_resp}, 64'd1);
        end
        check("t6_cmd_ready_blocked", {63'd0, cmd_ready}, 64'd0);
        consume();
        bresp_val = 2'b00;
        b_hold = 1'b1;
        send(1'b1, 1'b0, 32'h60, 64'h66, 8'hFF, 64'd0, ta);
        for (int i = 0; i < 20; i++) begin
            if (BREADY) break;
            @(posedge clk); #1;
        end
        check("t6_in_wb", {63'd0, BREADY}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_valids", {58'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 64'd0);
        check("t6_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        reset = 1'b0;
        b_hold = 1'b0;
        #1;
        check("t6_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_rsp_discarded", {63'd0, rsp_valid}, 64'd0);
        check("t6_idle_bready", {63'd0, BREADY}, 64'd0);

        // Protocol invariants across the whole run.
        check("never_aw_and_ar", {63'd0, overlap_seen}, 64'd0);
        check("no_early_bready", {63'd0, bready_early}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
